dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single data-memory port between the CPU load/store path and a DMA/loader port.
//  Serialises accesses through a small FSM and pulses an ack to the winning requester.
//  Drives a stall to the CPU (PC hold) while its access is pending.
//  Sits between the processor top, the loader/DMA engine and the data memory (sync write, comb read).
// PARAMETERS
//  AW         32  address width, both requesters and memory
//  DW         32  data width
//  MAX_BURST  8   max consecutive locked DMA accesses before a forced release (>=1)
// PORTS
//  clk             in   1   single clock, rising edge
//  rst             in   1   synchronous, active-high reset
//  cpu_req         in   1   CPU access request; held until cpu_ack
//  cpu_wen         in   1   1=store, 0=load
//  cpu_addr        in   AW  CPU byte address (ALU result)
//  cpu_wdata       in   DW  CPU store data
//  cpu_ack         out  1   one-cycle completion pulse
//  cpu_rdata       out  DW  load data, valid only when cpu_ack=1, else 0
//  cpu_stall       out  1   cpu_req & ~cpu_ack (combinational)
//  dma_req         in   1   DMA access request; held until dma_ack
//  dma_lock        in   1   request to keep ownership for following accesses
//  dma_wen         in   1   1=write, 0=read
//  dma_addr        in   AW  DMA address
//  dma_wdata       in   DW  DMA write data
//  dma_ack         out  1   one-cycle completion pulse
//  dma_rdata       out  DW  read data, valid only when dma_ack=1, else 0
//  mem_address     out  AW  to data memory
//  mem_write_en    out  1   to data memory
//  mem_write_data  out  DW  to data memory
//  mem_read_data   in   DW  from data memory (combinational read)
//  owner           out  1   0=CPU, 1=DMA: current/last granted requester
// BEHAVIOUR
//  Reset: FSM=IDLE, owner=0, burst_cnt=0, latches=0, rr_last=DMA. All outputs are 0.
//  Reset gating: mem_write_en, cpu_ack and dma_ack are gated with ~rst. No write or ack occurs in any cycle with rst=1.
//  IDLE:
//   - If any req: pick winner (arbitration below).
//   - Latch its addr/wdata/wen, set owner, go ACCESS.
//   - Else stay IDLE. mem_write_en=0, mem_address=0.
//  ACCESS (exactly 1 cycle):
//   - mem_* driven from latches; memory write occurs at the closing clk edge.
//   - Owner's ack=1; owner's rdata=mem_read_data.
//   - Next state: LOCKED if owner=DMA & dma_lock=1 & burst_cnt+1<MAX_BURST; else IDLE.
//  LOCKED:
//   - Only DMA may win. CPU waits even if pending.
//   - If dma_req: latch DMA, burst_cnt++, go ACCESS.
//   - If dma_lock=0 or dma_req=0: go IDLE, burst_cnt=0.
//  burst_cnt:
//   - Counts locked DMA accesses; cleared on every return to IDLE.
//   - Reaching MAX_BURST forces IDLE; a pending CPU req then wins.
//  Latency: req sampled in IDLE at cycle N -> ack at N+1. Min 2 cycles per access; peak 1 access / 2 cycles.
//  Owner's req is ignored during its own ACCESS cycle. Requester drops req the cycle after ack.
//  Req withdrawn after latch: access still completes and ack still pulses.
//  Simultaneous req in IDLE: resolved by arbitration mode. The loser stays stalled, no ack.
//  Address/data have no width conversion; passed through unchanged.
// CONFIGURATION
//  DMEM_ARB_RR_EN defined:
//   - Round-robin in IDLE; on tie, the requester not in rr_last wins.
//   - rr_last updates on every ACCESS.
//  DMEM_ARB_RR_EN undefined:
//   - Fixed priority, CPU always wins ties in IDLE.
//   - rr_last unused.
//  LOCKED and MAX_BURST rules apply in both modes.
// TESTING
//  1 CPU store: cpu_req=1 wen=1 addr=0x10 wdata=0xDEADBEEF, cycle 1 -> mem_write_en=1 in cycle 2 with cpu_ack=1. Then CPU load 0x10 -> cpu_rdata=0xDEADBEEF on ack.
//  2 Tie: both req in IDLE, rr_last=DMA.
//    - RR build: CPU acked first, DMA acked 2 cycles later.
//    - Fixed build: CPU wins every tie across 3 repeated ties.
//  3 Locked burst: MAX_BURST=4, dma_lock=1, dma_req held, cpu_req raised mid-burst.
//    - Exactly 4 dma_ack pulses, then cpu_ack.
//    - cpu_stall=1 throughout.
//  4 Lock drop: dma_lock deasserted after 2nd DMA ack with cpu_req pending -> FSM IDLE, burst_cnt=0, next ack goes to CPU.
//  5 Reset mid-op: rst=1 during ACCESS of a DMA write to 0x20.
//    - mem_write_en=0, dma_ack=0; 0x20 unchanged.
//    - Next cycle all outputs 0, FSM=IDLE.
//  6 Idle: no reqs for 10 cycles -> mem_write_en, acks, stall all 0, owner unchanged.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares the single data-memory port between the CPU load/store path and a
//   DMA/loader port. Every access takes an IDLE (or LOCKED) decision cycle and
//   one ACCESS cycle, during which the winner gets a one-cycle ack.
//
//   Configuration macro: DMEM_ARB_RR_EN
//     defined   : round-robin tie break in IDLE (requester not served last wins)
//     undefined : fixed priority, CPU wins ties in IDLE
//
//   Ports
//     clk, rst                          clock, synchronous active-high reset
//     cpu_req/wen/addr/wdata -> cpu_ack/rdata/stall   CPU load/store path
//     dma_req/lock/wen/addr/wdata -> dma_ack/rdata    DMA/loader path
//     mem_address/write_en/write_data, mem_read_data  data memory
//                                                     (sync write, comb read)
//     owner                             0=CPU, 1=DMA, last granted requester
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          cpu_req,
    input  logic          cpu_wen,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,

    input  logic          dma_req,
    input  logic          dma_lock,
    input  logic          dma_wen,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,

    output logic [AW-1:0] mem_address,
    output logic          mem_write_en,
    output logic [DW-1:0] mem_write_data,
    input  logic [DW-1:0] mem_read_data,

    output logic          owner
);

    // Wide enough to hold MAX_BURST itself.
    localparam int unsigned BCW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e         state_q,     state_d;
    logic           owner_q,     owner_d;
    logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
    logic [AW-1:0]  addr_q,      addr_d;
    logic [DW-1:0]  wdata_q,     wdata_d;
    logic           wen_q,       wen_d;
`ifdef DMEM_ARB_RR_EN
    logic           rr_last_q,   rr_last_d;   // 1 = DMA was served last
`endif

    logic           grant_dma;
    logic           burst_room;
    logic           access_live;

    // Another locked access is allowed only while the burst stays below MAX_BURST.
    assign burst_room = (32'(burst_cnt_q) + 32'd1) < MAX_BURST;

    // Next-state, winner selection and request latching.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wen_d       = wen_q;
`ifdef DMEM_ARB_RR_EN
        rr_last_d   = rr_last_q;
`endif
        grant_dma   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                burst_cnt_d = '0;
                if (cpu_req || dma_req) begin
`ifdef DMEM_ARB_RR_EN
                    // On a tie the requester that was not served last wins.
                    grant_dma = dma_req && (!cpu_req || !rr_last_q);
`else
                    grant_dma = !cpu_req;
`endif
                    addr_d  = grant_dma ? dma_addr  : cpu_addr;
                    wdata_d = grant_dma ? dma_wdata : cpu_wdata;
                    wen_d   = grant_dma ? dma_wen   : cpu_wen;
                    owner_d = grant_dma;
                    state_d = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
`ifdef DMEM_ARB_RR_EN
                rr_last_d = owner_q;
`endif
                // Requests are not sampled here; the owner's req is still up.
                if (owner_q && dma_lock && burst_room) begin
                    state_d = ST_LOCKED;
                end else begin
                    state_d     = ST_IDLE;
                    burst_cnt_d = '0;
                end
            end

            ST_LOCKED: begin
                // Only the DMA may continue; a pending CPU request keeps waiting.
                if (dma_req && dma_lock) begin
                    addr_d      = dma_addr;
                    wdata_d     = dma_wdata;
                    wen_d       = dma_wen;
                    owner_d     = 1'b1;
                    burst_cnt_d = burst_cnt_q + 1'b1;
                    state_d     = ST_ACCESS;
                end else begin
                    state_d     = ST_IDLE;
                    burst_cnt_d = '0;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    // State and latch registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            burst_cnt_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wen_q       <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            rr_last_q   <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wen_q       <= wen_d;
`ifdef DMEM_ARB_RR_EN
            rr_last_q   <= rr_last_d;
`endif
        end
    end

    // Write enable and acks are suppressed in any cycle with reset asserted.
    assign access_live    = (state_q == ST_ACCESS) && !rst;

    assign mem_address    = (state_q == ST_ACCESS) ? addr_q  : '0;
    assign mem_write_data = (state_q == ST_ACCESS) ? wdata_q : '0;
    assign mem_write_en   = access_live && wen_q;

    assign cpu_ack        = access_live && !owner_q;
    assign dma_ack        = access_live &&  owner_q;
    assign cpu_rdata      = cpu_ack ? mem_read_data : '0;
    assign dma_rdata      = dma_ack ? mem_read_data : '0;
    assign cpu_stall      = cpu_req && !cpu_ack;
    assign owner          = owner_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_port_arbiter
//   Bench for dmem_port_arbiter with MAX_BURST=4 and a small word memory.
//   Honours DMEM_ARB_RR_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

    localparam int unsigned AW        = 32;
    localparam int unsigned DW        = 32;
    localparam int unsigned MB        = 4;
    localparam int unsigned MEM_WORDS = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_wen;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack, cpu_stall;
    logic [DW-1:0] cpu_rdata;
    logic          dma_req, dma_lock, dma_wen;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_ack;
    logic [DW-1:0] dma_rdata;
    logic [AW-1:0] mem_address;
    logic          mem_write_en;
    logic [DW-1:0] mem_write_data;
    logic [DW-1:0] mem_read_data;
    logic          owner;

    dmem_port_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_lock(dma_lock), .dma_wen(dma_wen), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_address(mem_address), .mem_write_en(mem_write_en),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .owner(owner)
    );

    always #5 clk = ~clk;

    // Data memory: synchronous write, combinational read, word indexed.
    logic          mem_clr;
    logic [DW-1:0] mem [MEM_WORDS];
    assign mem_read_data = mem[mem_address[9:2]];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] <= '0;
        end else if (mem_write_en) begin
            mem[mem_address[9:2]] <= mem_write_data;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct { int cyc; bit who; } ack_t;   // who: 0=CPU, 1=DMA
    ack_t ack_log[$];

    function automatic int log_who(input int i);
        if (i < ack_log.size()) return int'(ack_log[i].who);
        return -1;
    endfunction

    function automatic int log_cyc(input int i);
        if (i < ack_log.size()) return ack_log[i].cyc;
        return -1000;
    endfunction

    // Reference: one transaction in flight at most, a DMA reservation with a
    // burst count, and a word memory that only changes on completed writes.
    logic          chk_en = 1'b0;
    bit            cpu_ack_s = 1'b0, dma_ack_s = 1'b0;
    int            stall_cycles = 0;
    bit            m_acc = 0, m_who = 0, m_wen = 0, m_held = 0, m_owner = 0, m_rr_last = 1;
    int            m_burst = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] ref_mem [MEM_WORDS];

    always @(negedge clk) begin
        bit            live, e_cack, e_dack, win;
        logic [DW-1:0] e_rd;
        live   = m_acc && !rst;
        e_cack = live && !m_who;
        e_dack = live &&  m_who;
        e_rd   = ref_mem[m_addr[9:2]];
        if (chk_en) begin
            check("cpu_ack",        cpu_ack,        e_cack);
            check("dma_ack",        dma_ack,        e_dack);
            check("mem_write_en",   mem_write_en,   live && m_wen);
            check("mem_address",    mem_address,    m_acc ? m_addr : '0);
            check("mem_write_data", mem_write_data, m_acc ? m_wdata : '0);
            check("cpu_rdata",      cpu_rdata,      e_cack ? e_rd : '0);
            check("dma_rdata",      dma_rdata,      e_dack ? e_rd : '0);
            check("cpu_stall",      cpu_stall,      cpu_req && !e_cack);
            check("owner",          owner,          m_owner);
        end
        cpu_ack_s = (cpu_ack === 1'b1);
        dma_ack_s = (dma_ack === 1'b1);
        if (cpu_ack_s) ack_log.push_back('{cyc, 1'b0});
        if (dma_ack_s) ack_log.push_back('{cyc, 1'b1});
        if (cpu_stall === 1'b1) stall_cycles++;
        cyc++;

        // Advance the reference by one clock.
        if (mem_clr) for (int i = 0; i < int'(MEM_WORDS); i++) ref_mem[i] = '0;
        if (rst) begin
            m_acc = 0; m_held = 0; m_burst = 0; m_owner = 0; m_rr_last = 1;
        end else if (m_acc) begin
            if (m_wen) ref_mem[m_addr[9:2]] = m_wdata;
            m_rr_last = m_who;
            m_acc     = 0;
            m_held    = m_who && dma_lock && (m_burst + 1 < int'(MB));
            if (!m_held) m_burst = 0;
        end else if (m_held) begin
            if (dma_req && dma_lock) begin
                m_acc = 1; m_who = 1; m_owner = 1;
                m_addr = dma_addr; m_wdata = dma_wdata; m_wen = dma_wen;
                m_burst++;
            end else begin
                m_held = 0; m_burst = 0;
            end
        end else if (cpu_req || dma_req) begin
`ifdef DMEM_ARB_RR_EN
            win = (cpu_req && dma_req) ? !m_rr_last : dma_req;
`else
            win = !cpu_req;
`endif
            m_acc = 1; m_who = win; m_owner = win;
            m_addr  = win ? dma_addr  : cpu_addr;
            m_wdata = win ? dma_wdata : cpu_wdata;
            m_wen   = win ? dma_wen   : cpu_wen;
        end
    end

    bit dma_keep = 1'b0;

    // Advance one clock; requesters drop their request the cycle after ack.
    task automatic step();
        @(posedge clk);
        #1;
        if (cpu_ack_s) cpu_req = 1'b0;
        if (dma_ack_s && !dma_keep) dma_req = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic cpu_issue(input logic wen, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        cpu_req = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wd;
    endtask

    task automatic dma_issue(input logic lock, input logic wen, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wd);
        dma_req = 1'b1; dma_lock = lock; dma_wen = wen; dma_addr = addr; dma_wdata = wd;
    endtask

    task automatic tie_test(input string tag, input bit exp_first_dma);
        ack_log.delete();
        cpu_issue(1'b0, 32'h10, '0);
        dma_issue(1'b0, 1'b0, 32'h40, '0);
        run(8);
        check({tag, " ack count"}, 64'(ack_log.size()), 2);
        check({tag, " first"},  64'(log_who(0)), 64'(exp_first_dma));
        check({tag, " second"}, 64'(log_who(1)), 64'(!exp_first_dma));
        check({tag, " gap"},    64'(log_cyc(1) - log_cyc(0)), 2);
    endtask

    initial begin
        int n_dma, bad;
        bit cpu_raised;
        rst = 1'b1; mem_clr = 1'b1;
        cpu_req = 0; cpu_wen = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_lock = 0; dma_wen = 0; dma_addr = '0; dma_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        mem_clr = 1'b0;
        chk_en  = 1'b1;

        // Reset state
        @(negedge clk);
        check("reset cpu_ack", cpu_ack, 0);
        check("reset dma_ack", dma_ack, 0);
        check("reset mem_write_en", mem_write_en, 0);
        check("reset mem_address", mem_address, 0);
        check("reset owner", owner, 0);
        step();
        rst = 1'b0;
        run(2);

        // CPU store then load of 0x10
        cpu_issue(1'b1, 32'h10, 32'hDEAD_BEEF);
        step();
        @(negedge clk);
        check("store wen", mem_write_en, 1);
        check("store ack", cpu_ack, 1);
        check("store addr", mem_address, 32'h10);
        run(3);
        cpu_issue(1'b0, 32'h10, '0);
        step();
        @(negedge clk);
        check("load ack", cpu_ack, 1);
        check("load data", cpu_rdata, 32'hDEAD_BEEF);
        run(3);

        // DMA-only access so the last served requester is the DMA
        dma_issue(1'b0, 1'b1, 32'h40, 32'hCAFE_F00D);
        run(4);
        for (int i = 0; i < 3; i++) tie_test("tie after dma", 1'b0);

        // CPU-only access, then a tie
        cpu_issue(1'b0, 32'h40, '0);
        run(4);
`ifdef DMEM_ARB_RR_EN
        tie_test("tie after cpu", 1'b1);
`else
        tie_test("tie after cpu", 1'b0);
`endif

        // Lock dropped after the 2nd DMA ack with a CPU request pending
        ack_log.delete();
        dma_keep = 1'b1; n_dma = 0; stall_cycles = 0;
        dma_issue(1'b1, 1'b0, 32'h40, '0);
        for (int i = 0; i < 40; i++) begin
            step();
            if (dma_ack_s) begin
                n_dma++;
                if (n_dma == 1) cpu_issue(1'b0, 32'h40, '0);
                if (n_dma == 2) dma_lock = 1'b0;
            end
            if (cpu_ack_s) begin dma_req = 1'b0; break; end
        end
        dma_keep = 1'b0;
        run(4);
        check("lockdrop count", 64'(ack_log.size()), 3);
        check("lockdrop who", 64'({log_who(0), log_who(1), log_who(2)}), 64'({32'd1, 32'd1, 32'd0}));
        check("lockdrop cpu gap", 64'(log_cyc(2) - log_cyc(1)), 3);
        check("lockdrop stall", 64'(stall_cycles), 4);

        // Locked burst capped at MAX_BURST with a CPU request raised mid-burst
        ack_log.delete();
        dma_keep = 1'b1; cpu_raised = 1'b0; stall_cycles = 0;
        dma_issue(1'b1, 1'b0, 32'h40, '0);
        for (int i = 0; i < 40; i++) begin
            step();
            if (dma_ack_s && !cpu_raised) begin cpu_issue(1'b0, 32'h10, '0); cpu_raised = 1'b1; end
            if (cpu_ack_s) begin dma_req = 1'b0; dma_lock = 1'b0; break; end
        end
        dma_keep = 1'b0;
        run(4);
        check("burst count", 64'(ack_log.size()), 5);
        check("burst who", 64'({log_who(0), log_who(1)}), 64'({32'd1, 32'd1}));
        check("burst who tail", 64'({log_who(2), log_who(3)}), 64'({32'd1, 32'd1}));
        check("burst cpu last", 64'(log_who(4)), 0);
        check("burst span", 64'(log_cyc(4) - log_cyc(0)), 8);
        check("burst stall", 64'(stall_cycles), 7);

        // Reset during the ACCESS cycle of a DMA write to 0x20
        cpu_issue(1'b1, 32'h20, 32'h1234_5678);
        run(4);
        dma_issue(1'b0, 1'b1, 32'h20, 32'h5555_AAAA);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("rst mid wen", mem_write_en, 0);
        check("rst mid dma_ack", dma_ack, 0);
        step();
        rst = 1'b0; dma_req = 1'b0;
        @(negedge clk);
        check("post rst outs", {mem_write_en, cpu_ack, dma_ack, cpu_stall, owner}, 0);
        check("post rst addr", mem_address, 0);
        check("post rst 0x20", mem[8], 32'h1234_5678);
        run(3);

        // Idle: nothing moves and owner is kept
        dma_issue(1'b0, 1'b0, 32'h20, '0);
        run(4);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge clk);
            if ({mem_write_en, cpu_ack, dma_ack, cpu_stall} !== 4'b0) bad++;
        end
        check("idle quiet", 64'(bad), 0);
        check("idle owner", owner, 1);

        // Randomized traffic with occasional resets
        ack_log.delete();
        dma_keep = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            step();
            rst = ($urandom_range(0, 249) == 0);
            if (!cpu_req && !cpu_ack_s && $urandom_range(0, 2) == 0)
                cpu_issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2, 32'($urandom));
            if (dma_ack_s) begin
                if ($urandom_range(0, 1) == 1)
                    dma_issue(dma_lock, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2,
                              32'($urandom));
                else
                    dma_req = 1'b0;
            end else if (!dma_req && $urandom_range(0, 2) == 0) begin
                dma_issue(1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2,
                          32'($urandom));
            end
            dma_lock = ($urandom_range(0, 3) != 0);
        end
        rst = 1'b0; cpu_req = 1'b0; dma_req = 1'b0; dma_keep = 1'b0;
        run(6);
        check("random acks seen", 64'(ack_log.size() > 200), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
